string_hw_arbiter: RTL and testbench

- Shares one string accelerator engine (compare / to-upper / to-lower, go/done handshake, 32-byte operands) between NREQ software-facing requesters.
- Sequences the engine for each request:
  - latches the winner's operands;
  - drives go until done;
  - waits for done to clear;
  - returns the latched result to the winner with a one-cycle ack.
- Sits between the Avalon/Nios II register front-ends and the engine instance.

---
 rtl/string_hw_arbiter.sv | 172 +++++++++++++++++
 tb/tb_string_hw_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_hw_arbiter.sv
// Round-robin arbiter sharing one string engine (cmp / upper / lower) among NREQ requesters.
// Optional engine watchdog: define STRARB_TIMEOUT_EN (abort after TIMEOUT cycles).
module string_hw_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_BLOCKS = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*4-1:0]             req_index,
    input  logic [NREQ*MAX_BLOCKS*32-1:0] req_a,
    input  logic [NREQ*MAX_BLOCKS*32-1:0] req_b,
    output logic [NREQ-1:0]               ack,
    output logic                          err,
    output logic [MAX_BLOCKS*32-1:0]      rsp_data,
    output logic                          busy,
    output logic                          eng_go,
    output logic [3:0]                    eng_index,
    output logic [MAX_BLOCKS*32-1:0]      eng_a,
    output logic [MAX_BLOCKS*32-1:0]      eng_b,
    input  logic                          eng_done,
    input  logic [MAX_BLOCKS*32-1:0]      eng_result
);
    localparam int W  = MAX_BLOCKS * 32;
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, winner_q, win;
    logic          found, grant;
    logic          issued_q, err_q, err_d;
    logic [3:0]    index_q;
    logic [W-1:0]  a_q, b_q, cap_q, rsp_q;
    logic [3:0]    idx_arr [NREQ];
    logic [W-1:0]  a_arr   [NREQ];
    logic [W-1:0]  b_arr   [NREQ];

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
        logic [PW:0] s;
        s = {1'b0, v} + (PW+1)'(1);
        if (s >= (PW+1)'(NREQ)) s = '0;
        return s[PW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            idx_arr[i] = req_index[i*4 +: 4];
            a_arr[i]   = req_a[i*W +: W];
            b_arr[i]   = req_b[i*W +: W];
        end
    end

    // Round-robin search: first requester at or after ptr_q, wrapping NREQ-1 -> 0.
    always_comb begin
        logic [PW:0] sum;
        // NOTE: every variable assigned in a comb block gets a default first, so no latch is inferred.
        sum   = '0;
        found = 1'b0;
        win   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

`ifdef STRARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          abort_q;

    // After a watchdog abort the engine may still be busy; hold off until its done clears.
    assign grant = found && !(abort_q && eng_done);
`else
    assign grant = found;
`endif

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset lives inside the clocked block; state uses non-blocking assignments only.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    if (idx_arr[win] > 4'd2) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE:   if (issued_q && eng_done) state_d = DRAIN;
            DRAIN:   if (!eng_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef STRARB_TIMEOUT_EN
        if ((state_q == ISSUE || state_q == DRAIN) && state_d == state_q
            && cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
`endif
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) ack[winner_q] = 1'b1;
        err       = (state_q == RESP) && err_q;
        busy      = (state_q != IDLE);
        eng_go    = (state_q == ISSUE);
        eng_index = index_q;
        eng_a     = a_q;
        eng_b     = b_q;
        rsp_data  = rsp_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            winner_q <= '0;
            index_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cap_q    <= '0;
            rsp_q    <= '0;
            err_q    <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            // A done seen on the first ISSUE cycle is stale from a previous job.
            issued_q <= (state_q == ISSUE);
            if (state_q == IDLE && grant) begin
                winner_q <= win;
                index_q  <= idx_arr[win];
                a_q      <= a_arr[win];
                b_q      <= b_arr[win];
                ptr_q    <= inc_wrap(win);
            end
            if (state_q == ISSUE && issued_q && eng_done) cap_q <= eng_result;
            if (state_d == RESP && state_q != RESP) begin
                err_q <= err_d;
                rsp_q <= err_d ? '0 : cap_q;
            end
        end
    end

`ifdef STRARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state_q == IDLE)                           cnt_q <= '0;
            else if (state_q == ISSUE || state_q == DRAIN) cnt_q <= cnt_q + CW'(1);
            if (err_d && state_q != IDLE) abort_q <= 1'b1;
            else if (!eng_done)           abort_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_string_hw_arbiter.sv
// Directed bench for string_hw_arbiter: vector table plus multi-cycle sequences,
// driven against a small behavioural string engine with tunable latency/hold/hang.
module tb_string_hw_arbiter;
    localparam int NREQ       = 2;
    localparam int MAX_BLOCKS = 8;
    localparam int TIMEOUT    = 64;
    localparam int W          = MAX_BLOCKS * 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*4-1:0]    req_index;
    logic [NREQ*W-1:0]    req_a, req_b;
    logic [NREQ-1:0]      ack;
    logic                 err, busy, eng_go;
    logic [W-1:0]         rsp_data, eng_a, eng_b;
    logic [3:0]           eng_index;
    logic                 eng_done   = 1'b0;
    logic [W-1:0]         eng_result = '0;

    int n_pass = 0, n_total = 0;
    int go_cycles, overlap, hold_seen;
    bit go_start_done;

    int eng_lat  = 1;
    int eng_hold = 0;
    bit eng_hang = 1'b0;
    int lat_cnt  = 0;
    int hold_cnt = 0;

    string_hw_arbiter #(.NREQ(NREQ), .MAX_BLOCKS(MAX_BLOCKS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_index(req_index),
        .req_a(req_a), .req_b(req_b), .ack(ack), .err(err), .rsp_data(rsp_data),
        .busy(busy), .eng_go(eng_go), .eng_index(eng_index), .eng_a(eng_a),
        .eng_b(eng_b), .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] engine_fn(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [7:0]   c;
        r = '0;
        if (op == 4'd0) begin
            r[0] = (a == b);
        end else if (op == 4'd1 || op == 4'd2) begin
            for (int i = 0; i < W/8; i++) begin
                c = a[i*8 +: 8];
                if (op == 4'd1 && c >= 8'h61 && c <= 8'h7a)      c = c - 8'd32;
                else if (op == 4'd2 && c >= 8'h41 && c <= 8'h5a) c = c + 8'd32;
                r[i*8 +: 8] = c;
            end
        end
        return r;
    endfunction

    // Engine model: done rises eng_lat cycles into go, falls eng_hold+1 cycles after go drops.
    always @(posedge clk) begin
        if (eng_go && !eng_done && !eng_hang) begin
            if (lat_cnt + 1 >= eng_lat) begin
                eng_done   <= 1'b1;
                eng_result <= engine_fn(eng_index, eng_a, eng_b);
                lat_cnt    <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!eng_go && eng_done) begin
            if (hold_cnt >= eng_hold) begin
                eng_done <= 1'b0;
                hold_cnt <= 0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
    end

    function automatic logic [W-1:0] s2v(input string s);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < W/8; i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input int r, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        req_index[r*4 +: 4] = op;
        req_a[r*W +: W]     = a;
        req_b[r*W +: W]     = b;
        req[r]              = 1'b1;
    endtask

    task automatic wait_ack(input int budget, input string name, output bit ok);
        bit seen_go;
        ok = 1'b0; seen_go = 1'b0; go_start_done = 1'b0;
        go_cycles = 0; overlap = 0; hold_seen = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (eng_go && !seen_go) begin
                seen_go       = 1'b1;
                go_start_done = eng_done;
            end
            if (eng_go)              go_cycles++;
            if (eng_go && eng_done)  overlap++;
            if (!eng_go && eng_done) hold_seen++;
            if (ack != '0)           ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: no ack within %0d cycles, required an ack", name, budget);
        end
    endtask

    task automatic wait_go(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (eng_go) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: eng_go never rose, required high", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int           r;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         exp_err;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        bit ok;
        logic [W-1:0] one;
        int cnt;
        one = '0;
        one[0] = 1'b1;

        vecs[0] = '{0, 4'd1, s2v("abcXYZ1"), '0, 1'b0, s2v("ABCXYZ1")};
        vecs[1] = '{1, 4'd2, s2v("HeLLo World!"), '0, 1'b0, s2v("hello world!")};
        vecs[2] = '{0, 4'd0, s2v("same text"), s2v("same text"), 1'b0, one};
        vecs[3] = '{1, 4'd0, s2v("abc"), s2v("abd"), 1'b0, '0};
        vecs[4] = '{1, 4'd7, s2v("junk"), s2v("junk"), 1'b1, '0};
        vecs[5] = '{0, 4'd3, s2v("junk"), s2v("junk"), 1'b1, '0};
        vecs[6] = '{0, 4'd15, s2v("junk"), s2v("junk"), 1'b1, '0};
        vecs[7] = '{1, 4'd1, s2v("z{@a`["), '0, 1'b0, s2v("Z{@A`[")};
        vecs[8] = '{0, 4'd2, s2v("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345"), '0, 1'b0,
                    s2v("abcdefghijklmnopqrstuvwxyz012345")};
        vecs[9] = '{0, 4'd0, s2v("0123456789abcdef0123456789abcdex"),
                    s2v("0123456789abcdef0123456789abcdey"), 1'b0, '0};

        req = '0; req_index = '0; req_a = '0; req_b = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, '0);
        check("rst_err", err, '0);
        check("rst_rsp", rsp_data, '0);
        check("rst_busy", busy, '0);
        check("rst_go", eng_go, '0);
        check("rst_index", eng_index, '0);
        check("rst_a", eng_a, '0);
        check("rst_b", eng_b, '0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ack(50, $sformatf("v%0d_wait", i), ok);
            if (ok) begin
                check($sformatf("v%0d_ack", i), ack, NREQ'(1) << vecs[i].r);
                check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
                check($sformatf("v%0d_data", i), rsp_data, vecs[i].exp);
                if (vecs[i].exp_err) check($sformatf("v%0d_go_cycles", i), go_cycles, 0);
                else                 check($sformatf("v%0d_go_done_overlap", i), overlap, 1);
            end
            req[vecs[i].r] = 1'b0;
            @(negedge clk);
            if (i == 0) begin
                check("v0_ack_one_cycle", ack, '0);
                check("v0_rsp_held", rsp_data, vecs[0].exp);
            end
        end

        // Simultaneous requests: 0 wins first, 1 is served before 0's repeat request.
        do_reset();
        drive(0, 4'd0, s2v("equal"), s2v("equal"));
        drive(1, 4'd0, s2v("twin"), s2v("twin"));
        wait_ack(50, "sim_first", ok);
        if (ok) begin
            check("sim_first_ack", ack, 2'b01);
            check("sim_first_data", rsp_data, one);
        end
        wait_ack(50, "sim_second", ok);
        if (ok) begin
            check("sim_second_ack", ack, 2'b10);
            check("sim_second_data", rsp_data, one);
        end
        req[1] = 1'b0;
        wait_ack(50, "sim_third", ok);
        if (ok) begin
            check("sim_third_ack", ack, 2'b01);
            check("sim_third_data", rsp_data, one);
        end
        req[0] = 1'b0;
        @(negedge clk);

        // Invalid index is rejected without ever starting the engine.
        drive(1, 4'd7, s2v("bad"), s2v("bad"));
        wait_ack(2, "inv_wait", ok);
        if (ok) begin
            check("inv_ack", ack, 2'b10);
            check("inv_err", err, 1'b1);
            check("inv_data", rsp_data, '0);
            check("inv_go", go_cycles, 0);
        end
        req[1] = 1'b0;
        @(negedge clk);

        // Reset while in ISSUE abandons the job.
        eng_hang = 1'b1;
        drive(0, 4'd1, s2v("abandon"), '0);
        wait_go("mid_rst_go", ok);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_go_low", eng_go, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", ack, '0);
        reset = 1'b1;
        req[0] = 1'b0;
        eng_hang = 1'b0;
        @(negedge clk);
        check("post_rst_ack", ack, '0);
        drive(0, 4'd2, s2v("HeLLo"), '0);
        wait_ack(50, "post_rst_wait", ok);
        if (ok) begin
            check("post_rst_ack_hot", ack, 2'b01);
            check("post_rst_data", rsp_data, s2v("hello"));
        end
        req[0] = 1'b0;
        @(negedge clk);

        // Engine holds done after go drops: ack waits for it, next go follows it.
        eng_hold = 5;
        drive(1, 4'd1, s2v("hold"), '0);
        drive(0, 4'd2, s2v("MiX"), '0);
        wait_ack(50, "hold_first", ok);
        if (ok) begin
            check("hold_first_ack", ack, 2'b10);
            check("hold_first_data", rsp_data, s2v("HOLD"));
            check("hold_done_low_at_ack", eng_done, 1'b0);
            check("hold_done_seen_5", hold_seen >= 5, 1'b1);
        end
        req[1] = 1'b0;
        wait_ack(50, "hold_second", ok);
        if (ok) begin
            check("hold_next_go_after_done", go_start_done, 1'b0);
            check("hold_second_ack", ack, 2'b01);
            check("hold_second_data", rsp_data, s2v("mix"));
        end
        req[0] = 1'b0;
        eng_hold = 0;
        repeat (8) @(negedge clk);

`ifdef STRARB_TIMEOUT_EN
        // Engine never answers: watchdog aborts TIMEOUT cycles after issue.
        eng_hang = 1'b1;
        drive(0, 4'd1, s2v("hang"), '0);
        wait_go("to_go", ok);
        if (ok) begin
            cnt = 0;
            ok  = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                cnt++;
                if (ack != '0) ok = 1'b1;
            end
            check("to_cycles", cnt, TIMEOUT);
            check("to_ack", ack, 2'b01);
            check("to_err", err, 1'b1);
            check("to_data", rsp_data, '0);
            check("to_go_low", eng_go, 1'b0);
        end
        req[0] = 1'b0;
        eng_hang = 1'b0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
